// File: rtl/sync_down_timer_pkg.sv
// Shared definitions for the synchronous down-timer.
//   timer_state_e : controller state (IDLE, RUN, DONE)
//   TIMER_WIDTH   : default counter/period width
package sync_down_timer_pkg;

  localparam int unsigned TIMER_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

endpackage : sync_down_timer_pkg

// File: rtl/sync_down_timer.sv
// Synchronous loadable down-counter/timer.
// A period is latched on start and counted down on enabled cycles. When the
// count reaches terminal count, a one-cycle tc pulse is produced. The timer
// then either reloads the period (auto_reload=1) or stops in DONE.
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   en           count enable
//   start        latch load_val as period, load count, enter RUN
//   stop         abort to IDLE, count holds
//   auto_reload  1: reload period at terminal count, 0: one-shot
//   load_val     period sampled when start=1
//   q            current count (registered)
//   tc           one-cycle terminal-count pulse (registered)
//   busy         state==RUN
//   done         state==DONE
module sync_down_timer
  import sync_down_timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             tc_q, tc_d;

  // Priority: stop > start > en (rst handled in the clocked block).
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    tc_d     = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      period_d = load_val;
      count_d  = load_val;
      // A zero period expires on the loading edge instead of wrapping.
      if (load_val == '0) begin
        state_d = DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN && en) begin
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else if (count_q == ONE) begin
        tc_d = 1'b1;
        if (auto_reload) begin
          count_d = period_q;
        end else begin
          count_d = '0;
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      tc_q     <= tc_d;
    end
  end

  assign q    = count_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule : sync_down_timer

// File: tb/tb_sync_down_timer.sv
module tb_sync_down_timer;

  logic       clk = 1'b0;
  logic       rst, en, start, stop, auto_reload;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, busy, done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  sync_down_timer #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .stop       (stop),
    .auto_reload(auto_reload),
    .load_val   (load_val),
    .q          (q),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, start, stop, en, ar;
    logic [3:0] lv;
    logic [3:0] q;
    logic       tc, busy, done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic p, logic e, logic a,
                              logic [3:0] lv, logic [3:0] eq, logic et,
                              logic eb, logic ed);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.en = e; v.ar = a; v.lv = lv;
    v.q = eq; v.tc = et; v.busy = eb; v.done = ed;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic p,
                       input logic e, input logic a, input logic [3:0] lv);
    rst = r; start = s; stop = p; en = e; auto_reload = a; load_val = lv;
  endtask

  task automatic check_all(input string tag, input logic [3:0] eq, input logic et,
                           input logic eb, input logic ed);
    check({tag, ".q"},    int'(q),    int'(eq));
    check({tag, ".tc"},   int'(tc),   int'(et));
    check({tag, ".busy"}, int'(busy), int'(eb));
    check({tag, ".done"}, int'(done), int'(ed));
  endtask

  // Reference model: timer phase, remaining count, latched period, pulse.
  typedef enum int {M_IDLE, M_RUN, M_EXPIRED} mphase_e;
  mphase_e m_phase;
  int      m_count, m_period;
  bit      m_tc;

  task automatic model_step(input bit r, input bit s, input bit p, input bit e,
                            input bit a, input int lv);
    m_tc = 0;
    if (r) begin
      m_phase = M_IDLE; m_count = 0; m_period = 0;
    end else if (p) begin
      m_phase = M_IDLE;
    end else if (s) begin
      m_period = lv;
      m_count  = lv;
      if (lv == 0) begin
        m_phase = M_EXPIRED; m_tc = 1;
      end else begin
        m_phase = M_RUN;
      end
    end else if (m_phase == M_RUN && e) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_tc = 1;
        if (a) m_count = m_period;
        else   m_phase = M_EXPIRED;
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 4'd0);

    // one-shot of 5
    vecs.push_back(mk(1,0,0,0,0, 4'd0, 4'd0, 0,0,0));
    vecs.push_back(mk(0,1,0,1,0, 4'd5, 4'd5, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd4, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd3, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd2, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd1, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd0, 1,0,1));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd0, 0,0,1));
    // auto-reload period 3
    vecs.push_back(mk(0,1,0,1,1, 4'd3, 4'd3, 0,1,0));
    for (int unsigned i = 0; i < 10; i++) begin
      case (i % 3)
        0: vecs.push_back(mk(0,0,0,1,1, 4'd0, 4'd2, 0,1,0));
        1: vecs.push_back(mk(0,0,0,1,1, 4'd0, 4'd1, 0,1,0));
        default: vecs.push_back(mk(0,0,0,1,1, 4'd0, 4'd3, 1,1,0));
      endcase
    end
    // en toggling, period 4, one-shot
    vecs.push_back(mk(0,1,0,1,0, 4'd4, 4'd4, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd3, 0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 4'd0, 4'd3, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd2, 0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 4'd0, 4'd2, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd1, 0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 4'd0, 4'd1, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd0, 1,0,1));
    // stop at q=2, then restart with 2
    vecs.push_back(mk(0,1,0,1,0, 4'd5, 4'd5, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd4, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd3, 0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd2, 0,1,0));
    vecs.push_back(mk(0,0,1,1,0, 4'd0, 4'd2, 0,0,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd2, 0,0,0));
    vecs.push_back(mk(0,1,1,1,0, 4'd9, 4'd2, 0,0,0));
    vecs.push_back(mk(0,1,0,0,0, 4'd2, 4'd2, 0,1,0));
    // reset mid-count, reset beats start
    vecs.push_back(mk(0,1,0,0,0, 4'd7, 4'd7, 0,1,0));
    vecs.push_back(mk(1,0,0,1,0, 4'd0, 4'd0, 0,0,0));
    vecs.push_back(mk(0,1,0,0,0, 4'd9, 4'd9, 0,1,0));
    vecs.push_back(mk(1,1,0,1,1, 4'd6, 4'd0, 0,0,0));
    // zero period expires on the loading edge
    vecs.push_back(mk(0,1,0,1,1, 4'd0, 4'd0, 1,0,1));
    vecs.push_back(mk(0,0,0,1,1, 4'd0, 4'd0, 0,0,1));
    // restart from DONE with period 1 reload: tc every cycle
    vecs.push_back(mk(0,1,0,1,1, 4'd1, 4'd1, 0,1,0));
    vecs.push_back(mk(0,0,0,1,1, 4'd0, 4'd1, 1,1,0));
    vecs.push_back(mk(0,0,0,1,1, 4'd0, 4'd1, 1,1,0));
    vecs.push_back(mk(0,0,0,1,0, 4'd0, 4'd0, 1,0,1));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].en,
            vecs[i].ar, vecs[i].lv);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].tc,
                vecs[i].busy, vecs[i].done);
    end

    // full-scale one-shot: tc after exactly 15 enabled cycles
    drive(0, 1, 0, 1, 0, 4'hF);
    @(posedge clk); #1;
    check_all("max.load", 4'hF, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 4'h0);
    for (int unsigned i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (i == 15) check_all("max.end", 4'h0, 1, 0, 1);
      else         check_all($sformatf("max.c%0d", i), 4'(15 - i), 0, 1, 0);
    end

    // randomized run against the reference model
    for (int unsigned i = 0; i < 3000; i++) begin
      bit r, s, p, e, a;
      int lv;
      r  = (i == 0) || ($urandom_range(0, 199) == 0);
      p  = ($urandom_range(0, 99) < 3);
      s  = ($urandom_range(0, 99) < 6);
      e  = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 2) != 0);
      lv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
      drive(r, s, p, e, a, 4'(lv));
      model_step(r, s, p, e, a, lv);
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", i), 4'(m_count), m_tc,
                m_phase == M_RUN, m_phase == M_EXPIRED);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sync_down_timer
